// File: rtl/snoopy_arbiter_pkg.sv
// Shared types and default parameters for the snoopy bus arbiter.
package snoopy_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_NUMBER_OF_DEVICES = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES    = 64;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin selector: first set request at or after the pointer,
// wrapping from the last device back to device 0.
module round_robin_picker #(
    parameter int unsigned NUMBER_OF_DEVICES = 4,
    parameter int unsigned OW                = 2
) (
    input  logic [NUMBER_OF_DEVICES-1:0] i_request,
    input  logic [OW-1:0]                i_pointer,
    output logic                         o_found_c,
    output logic [OW-1:0]                o_select_c
);

    localparam int unsigned N  = NUMBER_OF_DEVICES;
    localparam int unsigned SW = OW + 1;

    logic [SW-1:0] w_index;

    // Explicit wrap compare so non-power-of-two device counts work.
    always_comb begin
        o_found_c  = 1'b0;
        o_select_c = '0;
        w_index    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_index = {1'b0, i_pointer} + SW'(i);
            if (w_index >= SW'(N)) begin
                w_index = w_index - SW'(N);
            end
            if (!o_found_c && i_request[w_index[OW-1:0]]) begin
                o_found_c  = 1'b1;
                o_select_c = w_index[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// Round-robin owner arbitration for the shared snoopy bus with a one-cycle turnaround.
// Optional grant timeout and requester masking enabled by SNOOPY_ARBITER_TIMEOUT_EN.
module snoopy_bus_arbiter
    import snoopy_arbiter_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DEVICES = DEFAULT_NUMBER_OF_DEVICES,
    parameter int unsigned TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUMBER_OF_DEVICES-1:0]         request,
    output logic [NUMBER_OF_DEVICES-1:0]         grant,
    output logic                                 busValid,
    output logic [((NUMBER_OF_DEVICES > 1) ? $clog2(NUMBER_OF_DEVICES) : 1)-1:0] owner,
    output logic                                 timeout
);

    localparam int unsigned N  = NUMBER_OF_DEVICES;
    localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("snoopy_bus_arbiter: needs at least 2 devices and a nonzero timeout");
    end

    arb_state_e    r_state, w_state_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [OW-1:0] r_owner, w_owner_nxt;
    logic [OW-1:0] r_pointer, w_pointer_nxt;
    logic          r_bus_valid, w_bus_valid_nxt;
    logic          r_timeout, w_timeout_nxt;

    logic [N-1:0]  w_pick_request;
    logic          w_found;
    logic [OW-1:0] w_select;
    logic          w_owner_req;
    logic          w_expired;

    assign w_owner_req = request[r_owner];

`ifdef SNOOPY_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count, w_count_nxt;
    logic [N-1:0]  r_mask, w_mask_nxt;

    // Count reaches TIMEOUT_CYCLES on the edge that revokes the grant.
    assign w_expired      = (r_count == CW'(TIMEOUT_CYCLES - 1));
    assign w_pick_request = request & ~r_mask;

    // A timed-out device stays masked until it drops its request once.
    always_comb begin
        w_count_nxt = r_count;
        w_mask_nxt  = r_mask & request;
        if (r_state == IDLE && w_found) begin
            w_count_nxt = '0;
        end else if (r_state == GRANTED) begin
            w_count_nxt = r_count + CW'(1);
        end
        if (r_state == GRANTED && w_owner_req && w_expired) begin
            w_mask_nxt[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_mask  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_mask  <= w_mask_nxt;
        end
    end
`else
    assign w_expired      = 1'b0;
    assign w_pick_request = request;
`endif

    round_robin_picker #(
        .NUMBER_OF_DEVICES (N),
        .OW                (OW)
    ) u_picker (
        .i_request  (w_pick_request),
        .i_pointer  (r_pointer),
        .o_found_c  (w_found),
        .o_select_c (w_select)
    );

    // Next state and next registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_owner_nxt     = r_owner;
        w_bus_valid_nxt = r_bus_valid;
        w_pointer_nxt   = r_pointer;
        w_timeout_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_grant_nxt     = '0;
                w_owner_nxt     = '0;
                w_bus_valid_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt     = GRANTED;
                    w_grant_nxt     = {{(N-1){1'b0}}, 1'b1} << w_select;
                    w_owner_nxt     = w_select;
                    w_bus_valid_nxt = 1'b1;
                    w_pointer_nxt   = (w_select == OW'(N - 1)) ? '0 : w_select + OW'(1);
                end
            end
            GRANTED: begin
                if (!w_owner_req || w_expired) begin
                    w_state_nxt     = RELEASE;
                    w_grant_nxt     = '0;
                    w_owner_nxt     = '0;
                    w_bus_valid_nxt = 1'b0;
                    w_timeout_nxt   = w_owner_req;
                end
            end
            RELEASE: begin
                w_state_nxt     = IDLE;
                w_grant_nxt     = '0;
                w_owner_nxt     = '0;
                w_bus_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_grant_nxt     = '0;
                w_owner_nxt     = '0;
                w_bus_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_pointer   <= '0;
            r_bus_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_pointer   <= w_pointer_nxt;
            r_bus_valid <= w_bus_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign grant    = r_grant;
    assign owner    = r_owner;
    assign busValid = r_bus_valid;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed bench for snoopy_bus_arbiter: 4-device and 3-device instances.
module tb_snoopy_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] grant;
    logic       busValid;
    logic [1:0] owner;
    logic       timeout;

    logic [2:0] request3;
    logic [2:0] grant3;
    logic       busValid3;
    logic [1:0] owner3;
    logic       timeout3;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    snoopy_bus_arbiter #(.NUMBER_OF_DEVICES(4), .TIMEOUT_CYCLES(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .request  (request),
        .grant    (grant),
        .busValid (busValid),
        .owner    (owner),
        .timeout  (timeout)
    );

    snoopy_bus_arbiter #(.NUMBER_OF_DEVICES(3), .TIMEOUT_CYCLES(8)) dut3 (
        .clock    (clock),
        .reset    (reset),
        .request  (request3),
        .grant    (grant3),
        .busValid (busValid3),
        .owner    (owner3),
        .timeout  (timeout3)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic v, input logic t);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".owner"}, 32'(owner), 32'(o));
        chk({tag, ".busValid"}, 32'(busValid), 32'(v));
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic chk3(input string tag, input logic [2:0] g, input logic [1:0] o, input logic v);
        chk({tag, ".grant"}, 32'(grant3), 32'(g));
        chk({tag, ".owner"}, 32'(owner3), 32'(o));
        chk({tag, ".busValid"}, 32'(busValid3), 32'(v));
        chk({tag, ".timeout"}, 32'(timeout3), 32'(0));
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        request  = 4'b0000;
        request3 = 3'b000;
        tick(2);
        chk_bus("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk3("reset3", 3'b000, 2'd0, 1'b0);
        reset = 1'b0;

        // Single requester: grant one cycle after request, low one cycle after drop.
        request = 4'b0001;
        tick(1);
        chk_bus("single_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(4);
        chk_bus("single_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        request = 4'b0000;
        tick(1);
        chk_bus("single_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        chk_bus("single_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Full contention from pointer 0: order 0,1,2,3,0 with 2-cycle gaps.
        reset = 1'b1;
        tick(1);
        reset   = 1'b0;
        request = 4'b1111;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            int dev;
            dev = k % 4;
            chk_bus($sformatf("rr_grant%0d", k), 4'(1 << dev), 2'(dev), 1'b1, 1'b0);
            tick(2);
            chk_bus($sformatf("rr_hold%0d", k), 4'(1 << dev), 2'(dev), 1'b1, 1'b0);
            request[dev] = 1'b0;
            tick(1);
            chk_bus($sformatf("rr_gap_a%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
            request[dev] = 1'b1;
            tick(1);
            chk_bus($sformatf("rr_gap_b%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
            tick(1);
        end
        request = 4'b0000;
        tick(2);

        // Reset mid-grant, then re-arbitration from pointer 0.
        reset = 1'b1;
        tick(1);
        reset   = 1'b0;
        request = 4'b0100;
        tick(1);
        chk_bus("rst_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        reset   = 1'b1;
        request = 4'b0110;
        tick(1);
        chk_bus("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1);
        chk_bus("rst_rearb", 4'b0010, 2'd1, 1'b1, 1'b0);
        request = 4'b0100;
        tick(3);
        chk_bus("rst_next", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Pointer 3 with devices 0,1 requesting wraps to device 0.
        request = 4'b0000;
        tick(2);
        request = 4'b0011;
        tick(1);
        chk_bus("wrap_ptr3", 4'b0001, 2'd0, 1'b1, 1'b0);
        // Pointer 1 with devices 0,2 requesting picks device 2.
        request = 4'b0000;
        tick(2);
        request = 4'b0101;
        tick(1);
        chk_bus("ptr1_pick2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Request dropped in the first grant cycle still yields a one-cycle grant.
        request = 4'b0000;
        tick(2);
        request = 4'b1000;
        tick(1);
        chk_bus("oneshot_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        request = 4'b0000;
        tick(1);
        chk_bus("oneshot_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        chk_bus("oneshot_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Three devices: pointer 2 wraps to device 0, then pointer 1 favours device 1.
        reset = 1'b1;
        tick(1);
        reset    = 1'b0;
        request3 = 3'b010;
        tick(1);
        chk3("n3_dev1", 3'b010, 2'd1, 1'b1);
        request3 = 3'b000;
        tick(2);
        request3 = 3'b011;
        tick(1);
        chk3("n3_wrap", 3'b001, 2'd0, 1'b1);
        request3 = 3'b010;
        tick(1);
        chk3("n3_release", 3'b000, 2'd0, 1'b0);
        request3 = 3'b011;
        tick(2);
        chk3("n3_ptr1", 3'b010, 2'd1, 1'b1);
        request3 = 3'b000;
        tick(2);

`ifdef SNOOPY_ARBITER_TIMEOUT_EN
        // Device 1 holds the bus for 8 cycles, is revoked and stays masked.
        reset = 1'b1;
        tick(1);
        reset   = 1'b0;
        request = 4'b0010;
        tick(1);
        chk_bus("to_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(7);
        chk_bus("to_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        request = 4'b1010;
        tick(1);
        chk_bus("to_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(1);
        chk_bus("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        chk_bus("to_dev3", 4'b1000, 2'd3, 1'b1, 1'b0);
        request = 4'b0010;
        tick(3);
        chk_bus("to_masked", 4'b0000, 2'd0, 1'b0, 1'b0);
        request = 4'b0000;
        tick(1);
        request = 4'b0010;
        tick(1);
        chk_bus("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        request = 4'b0000;
        tick(2);
`else
        // Without the timeout feature a held grant never expires.
        request = 4'b0010;
        tick(1);
        chk_bus("hold_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(80);
        chk_bus("hold_long", 4'b0010, 2'd1, 1'b1, 1'b0);
        request = 4'b0000;
        tick(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
